// File: rtl/mipi_rx_hs_lane_ctrl.sv
// D-PHY RX data-lane HS-entry sequencer in the escape-clock domain: detects LP-11/01/00,
// times termination and settle, supervises deserializer sync and tears down on LP-11.
module mipi_rx_hs_lane_ctrl #(
   parameter int CNT_W        = 8,
   parameter int TERM_CNT     = 2,
   parameter int SETTLE_CNT   = 8,
   parameter int SYNC_TIMEOUT = 32
) (
   input  logic       RxClkEsc,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic       LP_DP,
   input  logic       LP_DN,
   input  logic       SYNC,
   input  logic       ERRSYNC,
   input  logic       NOSYNC,
   output logic       HS_TERM_EN,
   output logic       HS_DESER_EN,
   output logic       ENP,
   output logic       RX_ACTIVE_HS,
   output logic       RX_SYNC_HS,
   output logic       ERR_SOT_HS,
   output logic       ERR_SOT_SYNC_HS,
   output logic [2:0] STATE
);

   typedef enum logic [2:0] {
      ST_STOP    = 3'd0,
      ST_HS_RQST = 3'd1,
      ST_HS_PREP = 3'd2,
      ST_HS_SYNC = 3'd3,
      ST_HS_RCV  = 3'd4,
      ST_HS_ERR  = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] TERM_V      = CNT_W'(TERM_CNT);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CNT - 1);
   localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   // Synchronizer bit order: {dp, dn, sync, errsync, nosync}
   logic [4:0]       meta_q, sync_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lp11_q, lp11_d;
   logic             term_q, term_d;
   logic             deser_q, deser_d;
   logic             enp_q, enp_d;
   logic             act_q, act_d;
   logic             rxsync_q, rxsync_d;
   logic             errsot_q, errsot_d;
   logic             errsync_q, errsync_d;

   logic [1:0] lp;
   logic       lp_is11, f_sync, f_err, f_nosync, burst_exit;

   assign lp       = sync_q[4:3];
   assign f_sync   = sync_q[2];
   assign f_err    = sync_q[1];
   assign f_nosync = sync_q[0];
   assign lp_is11  = (lp == 2'b11);
   // Two consecutive synchronized LP-11 samples end a burst; one is treated as a glitch
   assign burst_exit = lp_is11 && lp11_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lp11_d    = 1'b0;
      rxsync_d  = 1'b0;
      errsot_d  = 1'b0;
      errsync_d = 1'b0;
      if (!ENABLE) begin
         state_d = ST_STOP;
      end else begin
         case (state_q)
            ST_STOP: begin
               if (lp == 2'b01) state_d = ST_HS_RQST;
            end
            ST_HS_RQST: begin
               if (lp == 2'b00) begin
                  state_d = ST_HS_PREP;
                  cnt_d   = '0;
               end else if (lp[1]) begin
                  state_d = ST_STOP;
               end
            end
            ST_HS_PREP: begin
               if (lp_is11) begin
                  state_d = ST_STOP;
               end else if (cnt_q == SETTLE_LAST) begin
                  state_d = ST_HS_SYNC;
                  cnt_d   = '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_HS_SYNC: begin
               lp11_d = lp_is11;
               if (burst_exit) begin
                  state_d = ST_STOP;
               end else if (f_sync) begin
                  state_d  = ST_HS_RCV;
                  rxsync_d = 1'b1;
               end else if (f_err) begin
                  state_d  = ST_HS_RCV;
                  rxsync_d = 1'b1;
                  errsot_d = 1'b1;
               end else if (f_nosync || cnt_q == SYNC_LAST) begin
                  state_d   = ST_HS_ERR;
                  errsync_d = 1'b1;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_HS_RCV, ST_HS_ERR: begin
               lp11_d = lp_is11;
               if (burst_exit) state_d = ST_STOP;
            end
            default: state_d = ST_STOP;
         endcase
      end

      // Outputs are decoded from the state being entered so they register on the same edge
      term_d  = (state_d == ST_HS_PREP && cnt_d >= TERM_V) ||
                state_d == ST_HS_SYNC || state_d == ST_HS_RCV || state_d == ST_HS_ERR;
      deser_d = (state_d == ST_HS_SYNC) || (state_d == ST_HS_RCV);
      enp_d   = (state_d == ST_HS_RCV);
      act_d   = (state_d == ST_HS_RCV);
   end

   always_ff @(posedge RxClkEsc) begin
      if (RESET) begin
         meta_q    <= '0;
         sync_q    <= '0;
         state_q   <= ST_STOP;
         cnt_q     <= '0;
         lp11_q    <= 1'b0;
         term_q    <= 1'b0;
         deser_q   <= 1'b0;
         enp_q     <= 1'b0;
         act_q     <= 1'b0;
         rxsync_q  <= 1'b0;
         errsot_q  <= 1'b0;
         errsync_q <= 1'b0;
      end else begin
         meta_q    <= {LP_DP, LP_DN, SYNC, ERRSYNC, NOSYNC};
         sync_q    <= meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lp11_q    <= lp11_d;
         term_q    <= term_d;
         deser_q   <= deser_d;
         enp_q     <= enp_d;
         act_q     <= act_d;
         rxsync_q  <= rxsync_d;
         errsot_q  <= errsot_d;
         errsync_q <= errsync_d;
      end
   end

   assign HS_TERM_EN      = term_q;
   assign HS_DESER_EN     = deser_q;
   assign ENP             = enp_q;
   assign RX_ACTIVE_HS    = act_q;
   assign RX_SYNC_HS      = rxsync_q;
   assign ERR_SOT_HS      = errsot_q;
   assign ERR_SOT_SYNC_HS = errsync_q;
   assign STATE           = state_q;

endmodule

// File: doc/mipi_rx_hs_lane_ctrl.md
Name: mipi_rx_hs_lane_ctrl

Overview:
- Escape-clock-domain sequencer for one D-PHY RX data lane, driving the HS deserializer's enable and byte-clock controls.
- Detects the LP-11 -> LP-01 -> LP-00 HS-entry sequence and times termination enable and settle.
- Enables the deserializer, supervises the SYNC/ERRSYNC/NOSYNC results, and tears HS mode down on LP-11.
- Sits between the lane's LP receivers and the HS deserializer; reports SoT status upward to the lane/protocol layer.

Parameters:
- CNT_W, 8, width of the timing counter.
- TERM_CNT, 2, cycles in HS_PREP before HS_TERM_EN asserts.
- SETTLE_CNT, 8, cycles in HS_PREP before the deserializer is enabled. Must be greater than TERM_CNT and less than 2^CNT_W.
- SYNC_TIMEOUT, 32, maximum cycles in HS_SYNC without a sync result.

Ports:
- RxClkEsc, in, 1, single block clock (escape/system clock).
- RESET, in, 1, synchronous active-high reset.
- ENABLE, in, 1, lane enable from configuration.
- LP_DP, in, 1, LP receiver output, Dp (asynchronous).
- LP_DN, in, 1, LP receiver output, Dn (asynchronous).
- SYNC, in, 1, deserializer exact sync-token flag (HS clock domain).
- ERRSYNC, in, 1, deserializer one-bit-error sync flag (HS clock domain).
- NOSYNC, in, 1, deserializer no-sync flag (HS clock domain).
- HS_TERM_EN, out, 1, HS termination enable.
- HS_DESER_EN, out, 1, deserializer enable; its falling edge clears the deserializer.
- ENP, out, 1, byte-clock enable to the deserializer.
- RX_ACTIVE_HS, out, 1, HS burst in progress.
- RX_SYNC_HS, out, 1, one-cycle pulse when SoT is accepted.
- ERR_SOT_HS, out, 1, one-cycle pulse when SoT is accepted with a one-bit error.
- ERR_SOT_SYNC_HS, out, 1, one-cycle pulse when SoT fails (NOSYNC or timeout).
- STATE, out, 3, current state encoding, for debug.

Behaviour:
- Input synchronization: LP_DP, LP_DN, SYNC, ERRSYNC and NOSYNC each pass through a 2-flop synchronizer on RxClkEsc. All decisions use the synchronized values, so input-to-decision latency is 2 cycles. LP state is written {dp,dn}.
- All outputs are registered and update on the clock edge that enters the new state.
- Reset: on RESET=1 at an edge, enter STOP, clear the counter and synchronizers, and drive every output 0.
- Event priority, highest first: RESET, ENABLE=0, LP-11 exit, SYNC, ERRSYNC, NOSYNC, timeout.
- From any state, ENABLE=0 -> STOP on the next edge, with all outputs 0.
- STOP (0):
  - All outputs 0.
  - LP=01 and ENABLE=1 -> HS_RQST.
- HS_RQST (1):
  - LP=00 -> HS_PREP, counter=0.
  - LP=11 or LP=10 -> STOP (escape entry is not handled here).
  - LP=01 -> stay.
- HS_PREP (2):
  - Counter increments every cycle and saturates at 2^CNT_W-1.
  - HS_TERM_EN=1 once counter>=TERM_CNT.
  - When counter=SETTLE_CNT-1 -> HS_SYNC, counter=0, HS_DESER_EN=1.
  - LP=11 -> STOP (aborted entry).
- HS_SYNC (3):
  - HS_TERM_EN=1, HS_DESER_EN=1, ENP=0. The byte clock is started by the deserializer itself on sync.
  - SYNC=1 -> HS_RCV with a RX_SYNC_HS pulse.
  - Else ERRSYNC=1 -> HS_RCV with RX_SYNC_HS and ERR_SOT_HS pulses together.
  - Else NOSYNC=1, or counter=SYNC_TIMEOUT-1 -> HS_ERR with an ERR_SOT_SYNC_HS pulse.
  - LP=11 held 2 consecutive cycles -> STOP.
- HS_RCV (4):
  - HS_TERM_EN=1, HS_DESER_EN=1, ENP=1, RX_ACTIVE_HS=1.
  - SYNC/ERRSYNC/NOSYNC are ignored.
  - LP=11 held 2 consecutive cycles -> STOP. All outputs are 0 on the edge entering STOP. A single-cycle LP=11 glitch does not exit.
- HS_ERR (5):
  - HS_DESER_EN=0, ENP=0, HS_TERM_EN=1, RX_ACTIVE_HS=0.
  - LP=11 held 2 consecutive cycles -> STOP.
- Codes 6 and 7 are illegal and -> STOP on the next edge.
- Pulse outputs are exactly one cycle wide and never re-fire within the same burst.
- SYNC and ERRSYNC arriving in the same cycle: treat as SYNC, with no ERR_SOT_HS.
- LP-11 and SYNC in the same cycle in HS_SYNC: the LP-11 count advances. On the second LP-11 cycle, exit takes priority.

Test Plan:
- Nominal burst: from STOP, drive LP 11->01 (4 cycles)->00, then SYNC=1 after 3 cycles in HS_SYNC, then LP=11 for 3 cycles.
  - STATE follows 0,1,2,3,4,0.
  - HS_TERM_EN rises 2 cycles after HS_PREP entry; HS_DESER_EN rises 8 cycles after HS_PREP entry.
  - RX_SYNC_HS is a single pulse; ENP=1 and RX_ACTIVE_HS=1 in HS_RCV.
  - All outputs are 0 two cycles after LP=11 is seen.
- One-bit error: ERRSYNC=1 in HS_SYNC -> RX_SYNC_HS and ERR_SOT_HS pulse in the same cycle, STATE=4.
- Sync failure:
  - NOSYNC=1 in HS_SYNC -> ERR_SOT_SYNC_HS pulse, STATE=5, HS_DESER_EN=0.
  - Separately, no flags for 32 cycles -> the same response.
  - LP=11 then -> STOP.
- Aborts:
  - LP 01->11 -> STOP with no outputs asserted.
  - LP=11 during HS_PREP at counter=5 -> STOP, HS_TERM_EN=0.
- Glitch and disable:
  - A single-cycle LP=11 in HS_RCV keeps STATE=4.
  - ENABLE=0 in HS_RCV -> STOP and all outputs 0 on the next edge.
- Reset mid-burst: RESET=1 during HS_RCV -> all outputs 0 and STATE=0 on that edge. The flow restarts cleanly after release.
